key_serial_loader: RTL and testbench



---
 rtl/key_serial_loader_if.sv | 24 ++
 rtl/key_serial_loader.sv | 158 +++++++++++++++
 tb/tb_key_serial_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_serial_loader_if.sv
// Serial key stream and committed-key bus between a key source and the loader.
// master drives the request and beats; slave is the loader itself.
interface key_serial_loader_if #(
   parameter int KEY_WIDTH = 3
);
   logic                 start;
   logic                 ser_valid;
   logic                 ser_data;
   logic                 ser_ready;
   logic [KEY_WIDTH-1:0] key_out;
   logic                 key_valid;
   logic                 busy;
   logic                 err;

   modport master (
      output start, ser_valid, ser_data,
      input  ser_ready, key_out, key_valid, busy, err
   );

   modport slave (
      input  start, ser_valid, ser_data,
      output ser_ready, key_out, key_valid, busy, err
   );
endinterface

// File: rtl/key_serial_loader.sv
// Bit-serial key loader for a locked netlist. Key bits arrive LSB first
// (keyIn0_0 first), followed by one even-parity trailer bit. The key is
// assembled in a shadow register and copied to key_out in a single edge only
// after the parity check succeeds, so the netlist never sees a partial key.
module key_serial_loader #(
   parameter int                   KEY_WIDTH = 3,
   parameter logic [KEY_WIDTH-1:0] RESET_KEY = '0,
   parameter int                   TIMEOUT   = 16
) (
   input logic                clk,
   input logic                rst,
   key_serial_loader_if.slave bus
);

   // Counter widths: the bit counter must hold KEY_WIDTH, the idle counter TIMEOUT.
   localparam int CW = $clog2(KEY_WIDTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] CHECK  = 3'd2;
   localparam logic [2:0] COMMIT = 3'd3;
   localparam logic [2:0] ERROR  = 3'd4;

   logic [2:0]           state_reg,  state_next;
   logic [CW-1:0]        count_reg,  count_next;
   logic                 parity_reg, parity_next;
   logic [TW-1:0]        tout_reg,   tout_next;
   logic [KEY_WIDTH-1:0] key_reg,    key_next;
   logic                 kv_reg,     kv_next;
   logic                 err_reg,    err_next;
   logic [KEY_WIDTH-1:0] shadow_reg;
   logic [KEY_WIDTH-1:0] shadow_we;
   logic                 shadow_clear;
   logic                 ready;
   logic                 beat;
   logic                 load_beat;

   // Ready is a pure function of state; no path from ser_valid back to ser_ready.
   assign ready     = (state_reg == LOAD) || (state_reg == CHECK);
   assign beat      = bus.ser_valid && ready;
   assign load_beat = beat && (state_reg == LOAD);

   assign bus.ser_ready = ready;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.key_out   = key_reg;
   assign bus.key_valid = kv_reg;
   assign bus.err       = err_reg;

   // One write strobe per shadow bit, selected by the current bit position.
   genvar gi;
   generate
      for (gi = 0; gi < KEY_WIDTH; gi++) begin : g_shadow_we
         assign shadow_we[gi] = load_beat && (count_reg == CW'(gi));
      end
   endgenerate

   // Next-state and datapath control for the load sequence.
   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      parity_next  = parity_reg;
      tout_next    = tout_reg;
      key_next     = key_reg;
      kv_next      = kv_reg;
      err_next     = err_reg;
      shadow_clear = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next   = LOAD;
               count_next   = '0;
               parity_next  = 1'b0;
               tout_next    = '0;
               err_next     = 1'b0;
               shadow_clear = 1'b1;
            end
         end
         LOAD: begin
            if (beat) begin
               parity_next = parity_reg ^ bus.ser_data;
               count_next  = count_reg + 1'b1;
               tout_next   = '0;
               if (count_reg == CW'(KEY_WIDTH - 1)) begin
                  state_next = CHECK;
               end
            end else begin
               tout_next = tout_reg + 1'b1;
               if (tout_reg == TW'(TIMEOUT - 1)) begin
                  state_next = ERROR;
               end
            end
         end
         CHECK: begin
            if (beat) begin
               tout_next = '0;
               if ((parity_reg ^ bus.ser_data) == 1'b0) begin
                  state_next = COMMIT;
               end else begin
                  state_next = ERROR;
               end
            end else begin
               tout_next = tout_reg + 1'b1;
               if (tout_reg == TW'(TIMEOUT - 1)) begin
                  state_next = ERROR;
               end
            end
         end
         COMMIT: begin
            key_next   = shadow_reg;
            kv_next    = 1'b1;
            state_next = IDLE;
         end
         ERROR: begin
            err_next   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Control and committed-key registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         parity_reg <= 1'b0;
         tout_reg   <= '0;
         key_reg    <= RESET_KEY;
         kv_reg     <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         parity_reg <= parity_next;
         tout_reg   <= tout_next;
         key_reg    <= key_next;
         kv_reg     <= kv_next;
         err_reg    <= err_next;
      end
   end

   // Shadow register collects the key bits; cleared at each accepted start.
   always_ff @(posedge clk) begin
      if (rst || shadow_clear) begin
         shadow_reg <= '0;
      end else begin
         for (int i = 0; i < KEY_WIDTH; i++) begin
            if (shadow_we[i]) begin
               shadow_reg[i] <= bus.ser_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_serial_loader.sv
// Self-checking bench for key_serial_loader: each load's expected outcome is
// queued when its beats are driven and compared when the loader finishes.
module tb_key_serial_loader;

   localparam int             KW = 3;
   localparam logic [KW-1:0]  RK = 3'b000;
   localparam int             TO = 4;

   typedef struct {
      logic [KW-1:0] key;
      logic          kv;
      logic          er;
      string         name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic [KW-1:0] model_key;
   logic          model_kv;

   key_serial_loader_if #(.KEY_WIDTH(KW)) bus ();

   key_serial_loader #(
      .KEY_WIDTH(KW),
      .RESET_KEY(RK),
      .TIMEOUT  (TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pop_and_check(input string tag);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard empty got=0 want=1 entries", tag);
         return;
      end
      e = sb.pop_front();
      total++;
      if (bus.key_out !== e.key) begin
         bad++;
         $display("FAIL %s key_out got=%b want=%b", e.name, bus.key_out, e.key);
      end
      total++;
      if (bus.key_valid !== e.kv) begin
         bad++;
         $display("FAIL %s key_valid got=%b want=%b", e.name, bus.key_valid, e.kv);
      end
      total++;
      if (bus.err !== e.er) begin
         bad++;
         $display("FAIL %s err got=%b want=%b", e.name, bus.err, e.er);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_after got=%b want=0", e.name, bus.busy);
      end
      $display("txn %s: key_out=%b key_valid=%b err=%b", e.name, bus.key_out, bus.key_valid, bus.err);
   endtask

   // Full load: start, KW key bits LSB first, parity trailer; gap idle cycles before each beat.
   task automatic run_load(input logic [KW-1:0] bits, input logic par, input int gap,
                           input logic pulse, input string name, output int rdy);
      exp_t e;
      logic good;
      good   = (((^bits) ^ par) == 1'b0);
      e.name = name;
      e.key  = good ? bits : model_key;
      e.kv   = good ? 1'b1 : model_kv;
      e.er   = !good;
      sb.push_back(e);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      total++;
      if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
         bad++;
         $display("FAIL %s start_accept busy/err got=%b/%b want=1/0", name, bus.busy, bus.err);
      end
      rdy = 0;
      for (int i = 0; i <= KW; i++) begin
         for (int g = 0; g < gap; g++) begin
            bus.ser_valid = 1'b0;
            bus.start     = pulse;
            if (bus.ser_ready === 1'b1) rdy++;
            tick;
            bus.start = 1'b0;
         end
         bus.ser_valid = 1'b1;
         bus.ser_data  = (i < KW) ? bits[i] : par;
         total++;
         if (bus.ser_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_beat%0d got=%b want=1", name, i, bus.ser_ready);
         end
         if (bus.ser_ready === 1'b1) rdy++;
         tick;
      end
      bus.ser_valid = 1'b0;
      // Closing cycle: still busy, not ready, committed key not yet changed.
      total++;
      if (bus.busy !== 1'b1 || bus.ser_ready !== 1'b0 ||
          bus.key_out !== model_key || bus.key_valid !== model_kv) begin
         bad++;
         $display("FAIL %s closing busy=%b ready=%b key=%b kv=%b want busy=1 ready=0 key=%b kv=%b",
                  name, bus.busy, bus.ser_ready, bus.key_out, bus.key_valid, model_key, model_kv);
      end
      tick;
      pop_and_check(name);
      if (good) begin
         model_key = bits;
         model_kv  = 1'b1;
      end
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_key = RK;
      model_kv  = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      total++;
      if (bus.key_out !== RK || bus.key_valid !== 1'b0 || bus.err !== 1'b0 ||
          bus.ser_ready !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s key=%b kv=%b err=%b ready=%b busy=%b want key=%b kv=0 err=0 ready=0 busy=0",
                  tag, bus.key_out, bus.key_valid, bus.err, bus.ser_ready, bus.busy, RK);
      end
      $display("txn %s: key_out=%b busy=%b", tag, bus.key_out, bus.busy);
   endtask

   task automatic test_reset;
      bus.start     = 1'b0;
      bus.ser_valid = 1'b0;
      bus.ser_data  = 1'b0;
      rst           = 1'b1;
      tick;
      apply_reset;
      check_reset_values("reset");
   endtask

   task automatic test_back_to_back;
      int rdy;
      run_load(3'b101, 1'b0, 0, 1'b0, "good_101", rdy);
      total++;
      if (rdy != KW + 1) begin
         bad++;
         $display("FAIL good_101 ready_cycles got=%0d want=%0d", rdy, KW + 1);
      end
   endtask

   task automatic test_parity_error;
      int rdy;
      run_load(3'b011, 1'b1, 0, 1'b0, "bad_parity", rdy);
      run_load(3'b110, 1'b0, 0, 1'b0, "good_110", rdy);
   endtask

   task automatic test_timeout;
      exp_t e;
      apply_reset;
      e.key = RK; e.kv = 1'b0; e.er = 1'b1; e.name = "timeout";
      sb.push_back(e);
      bus.start = 1'b1;
      tick;
      bus.start     = 1'b0;
      bus.ser_valid = 1'b1;
      bus.ser_data  = 1'b1;
      tick;
      bus.ser_valid = 1'b0;
      for (int k = 0; k < TO - 1; k++) begin
         tick;
         total++;
         if (bus.ser_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout idle%0d ready got=%b want=1", k, bus.ser_ready);
         end
      end
      tick;
      total++;
      if (bus.ser_ready !== 1'b0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL timeout error_state ready/busy got=%b/%b want=0/1", bus.ser_ready, bus.busy);
      end
      bus.ser_valid = 1'b1;
      tick;
      bus.ser_valid = 1'b0;
      pop_and_check("timeout");
      tick;
      total++;
      if (bus.ser_ready !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL timeout late_beat ready/busy got=%b/%b want=0/0", bus.ser_ready, bus.busy);
      end
   endtask

   task automatic test_reset_mid_load;
      int rdy;
      run_load(3'b101, 1'b0, 0, 1'b0, "pre_reset_101", rdy);
      bus.start = 1'b1;
      tick;
      bus.start     = 1'b0;
      bus.ser_valid = 1'b1;
      bus.ser_data  = 1'b1;
      tick;
      tick;
      bus.ser_valid = 1'b0;
      apply_reset;
      check_reset_values("reset_mid_load");
      run_load(3'b100, 1'b1, 0, 1'b0, "after_reset_100", rdy);
   endtask

   task automatic test_gaps_and_start;
      int rdy;
      run_load(3'b111, 1'b1, 2, 1'b1, "gap2_111", rdy);
      total++;
      if (rdy != (KW + 1) * 3) begin
         bad++;
         $display("FAIL gap2_111 ready_cycles got=%0d want=%0d", rdy, (KW + 1) * 3);
      end
      run_load(3'b010, 1'b1, TO - 1, 1'b0, "gap_max_010", rdy);
   endtask

   initial begin
      model_key = RK;
      model_kv  = 1'b0;
      test_reset;
      test_back_to_back;
      test_parity_error;
      test_timeout;
      test_reset_mid_load;
      test_gaps_and_start;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
